demux1to4_tdm: RTL and testbench

- Receive side of a 4-channel time-division link. The transmit side rotates a 2-bit select through a 4:1 mux, giving slots 0..3 on one lane.
- This block tracks slot position from a frame marker and steers each accepted sample into a per-channel shadow register.
- Once all four slots are captured, it publishes them atomically to four registered outputs.
- Sits directly downstream of the 4:1 mux lane in the BEGIN-level datapath examples.

---
 rtl/demux1to4_tdm.sv | 92 +++++++++
 tb/tb_demux1to4_tdm.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/demux1to4_tdm.sv
// demux1to4_tdm: 4-slot TDM receive demux; tracks slot position from a frame marker
// and publishes each complete frame atomically to four registered outputs.
module demux1to4_tdm #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [1:0]       sel,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sh0, sh1, sh2, sh0_n, sh1_n, sh2_n;
  logic [WIDTH-1:0] out0_n, out1_n, out2_n, out3_n;
  logic [1:0] sel_n;
  logic fv_n, se_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      sh0 <= '0;
      sh1 <= '0;
      sh2 <= '0;
      out0 <= '0;
      out1 <= '0;
      out2 <= '0;
      out3 <= '0;
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      sh0 <= sh0_n;
      sh1 <= sh1_n;
      sh2 <= sh2_n;
      out0 <= out0_n;
      out1 <= out1_n;
      out2 <= out2_n;
      out3 <= out3_n;
      frame_valid <= fv_n;
      sync_err <= se_n;
    end
  end
  // A marker always restarts at slot 0; mid-frame it also flags the dropped partial frame.
  always_comb begin
    state_n = state;
    sel_n = sel;
    sh0_n = sh0;
    sh1_n = sh1;
    sh2_n = sh2;
    out0_n = out0;
    out1_n = out1;
    out2_n = out2;
    out3_n = out3;
    fv_n = 1'b0;
    se_n = 1'b0;
    if (in_valid) begin
      if (frame_start) begin
        se_n = (state == RUN) && (sel != 2'd0);
        state_n = RUN;
        sh0_n = in;
        sel_n = 2'd1;
      end else if (state == RUN) begin
        if (sel == 2'd0) begin
          state_n = IDLE;
          se_n = 1'b1;
        end else if (sel == 2'd3) begin
          out0_n = sh0;
          out1_n = sh1;
          out2_n = sh2;
          out3_n = in;
          fv_n = 1'b1;
          sel_n = 2'd0;
        end else begin
          sh1_n = (sel == 2'd1) ? in : sh1;
          sh2_n = (sel == 2'd2) ? in : sh2;
          sel_n = sel + 2'd1;
        end
      end
    end
  end
  assign locked = (state == RUN);
endmodule

// File: tb/tb_demux1to4_tdm.sv
// tb_demux1to4_tdm: directed self-checking bench for the TDM receive demux.
module tb_demux1to4_tdm;
  logic clk = 1'b0;
  logic rst_n;
  logic [0:0] in;
  logic in_valid, frame_start;
  logic [0:0] out0, out1, out2, out3;
  logic [1:0] sel;
  logic frame_valid, sync_err, locked;
  int checks = 0;
  int errors = 0;

  demux1to4_tdm #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .frame_start(frame_start),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .sel(sel),
    .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic d, input logic v, input logic f);
    in = d;
    in_valid = v;
    frame_start = f;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  function automatic logic [3:0] outs();
    return {out3, out2, out1, out0};
  endfunction

  initial begin
    logic [3:0] fa, fb;
    rst_n = 1'b0;
    in = '0;
    in_valid = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", outs(), 4'b0000);
    chk("rst_sel", sel, 0);
    chk("rst_locked", locked, 0);
    chk("rst_pulses", {frame_valid, sync_err}, 0);
    rst_n = 1'b1;
    step(0, 0, 0);
    chk("idle_sel", sel, 0);
    // single frame 1,0,1,0
    step(0, 1, 0);
    chk("idle_ignore", {locked, sel}, 0);
    step(1, 1, 1);
    chk("s1_sel1", sel, 1);
    chk("s1_locked", locked, 1);
    step(0, 1, 0);
    chk("s1_sel2", sel, 2);
    step(1, 1, 0);
    chk("s1_sel3", sel, 3);
    chk("s1_nofv", frame_valid, 0);
    chk("s1_outs_hold", outs(), 4'b0000);
    step(0, 1, 0);
    chk("s1_fv", frame_valid, 1);
    chk("s1_sel0", sel, 0);
    chk("s1_outs", outs(), 4'b0101);
    step(0, 0, 0);
    chk("s1_fv_clear", frame_valid, 0);
    // gapped frame 1,0,1,0
    fa = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step(fa[i], 1, i == 0);
      chk("s2_fv_sample", frame_valid, i == 3);
      for (int g = 0; g < 2; g++) begin
        step(~fa[i], 0, 1);
        chk("s2_sel_hold", sel, (i + 1) % 4);
        chk("s2_fv_gap", frame_valid, 0);
      end
    end
    chk("s2_outs", outs(), 4'b0101);
    // back-to-back 1,0,1,0 then 0,1,1,1
    fb = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      step(fa[i], 1, i == 0);
      chk("s3_fv_a", frame_valid, i == 3);
    end
    chk("s3_outs_a", outs(), 4'b0101);
    for (int i = 0; i < 4; i++) begin
      step(fb[i], 1, i == 0);
      chk("s3_fv_b", frame_valid, i == 3);
    end
    chk("s3_outs_b", outs(), 4'b1110);
    // early marker at slot 2
    step(0, 1, 1);
    step(0, 1, 0);
    chk("s4_sel2", sel, 2);
    step(1, 1, 1);
    chk("s4_sync_err", sync_err, 1);
    chk("s4_sel1", sel, 1);
    chk("s4_locked", locked, 1);
    chk("s4_outs_keep", outs(), 4'b1110);
    step(0, 1, 0);
    chk("s4_se_clear", sync_err, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("s4_fv", frame_valid, 1);
    chk("s4_outs", outs(), 4'b1001);
    // missing marker after a complete frame
    step(1, 1, 0);
    chk("s5_sync_err", sync_err, 1);
    chk("s5_locked", locked, 0);
    chk("s5_outs_keep", outs(), 4'b1001);
    step(0, 1, 0);
    chk("s5_ignored", {sync_err, locked, sel}, 0);
    step(0, 1, 1);
    chk("s5_relock", {locked, sel}, 3'b101);
    // async reset at slot 2
    step(1, 1, 0);
    chk("s6_sel2", sel, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_async_outs", outs(), 4'b0000);
    chk("s6_async_state", {locked, sel, frame_valid, sync_err}, 0);
    step(1, 1, 0);
    chk("s6_held", {outs(), frame_valid}, 0);
    rst_n = 1'b1;
    fa = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      step(fa[i], 1, i == 0);
      chk("s6_fv", frame_valid, i == 3);
    end
    chk("s6_outs", outs(), 4'b0110);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
